conv1d_job_sequencer: RTL

Hardware sequencer that drives the conv1d engine's cmd/inp0/inp1/ret port to compute one filter across N output positions without CPU polling. Per position it performs these steps:
- programs the ring-buffer start slot;
- starts the engine and polls its done flag, with a timeout;
- reads the accumulator, adds a bias and streams the result out over valid/ready;
- requests a refill of the next input row.

It sits between the CFU command decoder and the conv1d engine. The host loads weights and the first 8 input rows before asserting job_start.

---
 rtl/conv1d_job_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv1d_job_sequencer.sv
// conv1d job sequencer: walks one filter across N output positions,
// driving the engine cmd port, streaming biased results, refilling rows.
module conv1d_job_sequencer #(
  parameter int CMD_NOP        = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POS_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_start,
  input  logic [POS_W-1:0] job_positions,
  input  logic [2:0]       job_first_slot,
  input  logic [31:0]      bias,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             eng_en,
  output logic [6:0]       eng_cmd,
  output logic [31:0]      eng_inp0,
  output logic [31:0]      eng_inp1,
  input  logic [31:0]      eng_ret,
  output logic             row_req,
  output logic [2:0]       row_slot,
  input  logic             row_ack,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [POS_W-1:0] res_index,
  input  logic             res_ready
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_X,
    S_START,
    S_POLL,
    S_CHK,
    S_READ,
    S_CAPT,
    S_PUSH,
    S_REFILL,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] positions_q, positions_d;
  logic [2:0]       slot_q, slot_d;
  logic [31:0]      bias_q, bias_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             eng_en_q, eng_en_d;
  logic [6:0]       eng_cmd_q, eng_cmd_d;
  logic [31:0]      eng_inp1_q, eng_inp1_d;
  logic             row_req_q, row_req_d;
  logic [2:0]       row_slot_q, row_slot_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [POS_W-1:0] res_index_q, res_index_d;
  logic             xfer;

  assign xfer = res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    positions_d = positions_q;
    slot_d      = slot_q;
    bias_d      = bias_q;
    timer_d     = timer_q;
    error_d     = error_q;
    done_d      = 1'b0;
    row_req_d   = row_req_q;
    row_slot_d  = row_slot_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    if (abort) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      row_req_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (job_start) begin
            if (job_positions != '0) begin
              positions_d = job_positions;
              slot_d      = job_first_slot;
              bias_d      = bias;
              pos_d       = '0;
              error_d     = 1'b0;
              state_d     = S_SET_X;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_SET_X: state_d = S_START;
        S_START: begin
          timer_d = '0;
          state_d = S_POLL;
        end
        S_POLL: state_d = S_CHK;
        S_CHK: begin
          if (eng_ret[0]) begin
            state_d = S_READ;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_READ: state_d = S_CAPT;
        S_CAPT: begin
          res_data_d  = eng_ret + bias_q;
          res_index_d = pos_q;
          res_valid_d = 1'b1;
          state_d     = S_PUSH;
        end
        S_PUSH: begin
          if (xfer) begin
            res_valid_d = 1'b0;
            if (pos_q == positions_q - POS_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_req_d  = 1'b1;
              row_slot_d = slot_q;
              state_d    = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (row_ack) begin
            row_req_d = 1'b0;
            slot_d    = slot_q + 3'd1;
            pos_d     = pos_q + POS_W'(1);
            state_d   = S_SET_X;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Engine-facing outputs are decoded from the next state so they
  // line up with the state register.
  always_comb begin
    busy_d     = !(state_d inside {S_IDLE, S_ERR});
    eng_en_d   = busy_d;
    eng_inp1_d = '0;
    unique case (state_d)
      S_SET_X: begin
        eng_cmd_d  = 7'd8;
        eng_inp1_d = {29'd0, slot_d};
      end
      S_START:       eng_cmd_d = 7'd6;
      S_POLL, S_CHK: eng_cmd_d = 7'd9;
      S_READ:        eng_cmd_d = 7'd7;
      default:       eng_cmd_d = 7'(CMD_NOP);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      positions_q <= '0;
      slot_q      <= '0;
      bias_q      <= '0;
      timer_q     <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      eng_en_q    <= 1'b0;
      eng_cmd_q   <= 7'(CMD_NOP);
      eng_inp1_q  <= '0;
      row_req_q   <= 1'b0;
      row_slot_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      positions_q <= positions_d;
      slot_q      <= slot_d;
      bias_q      <= bias_d;
      timer_q     <= timer_d;
      error_q     <= error_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      eng_en_q    <= eng_en_d;
      eng_cmd_q   <= eng_cmd_d;
      eng_inp1_q  <= eng_inp1_d;
      row_req_q   <= row_req_d;
      row_slot_q  <= row_slot_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign eng_en    = eng_en_q;
  assign eng_cmd   = eng_cmd_q;
  assign eng_inp0  = '0;
  assign eng_inp1  = eng_inp1_q;
  assign row_req   = row_req_q;
  assign row_slot  = row_slot_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_index = res_index_q;

endmodule
